// File: rtl/wall_datapath.sv
// wall_datapath: wall position, touch status and bar renderer for the VGA plot port.
// Define WALL_ERASE_EN to erase the previous bar before painting the new one.
module wall_datapath #(
    parameter int         START_X     = 156,
    parameter int         HIT_X       = 20,
    parameter int         STEP        = 1,
    parameter int         WALL_W      = 4,
    parameter logic [2:0] WALL_COLOUR = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] current,
    input  logic       tick,
    output logic       touched,
    output logic [7:0] wall_x,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy
);

    localparam logic [3:0] CUR_MOVE = 4'h6;
    localparam logic [3:0] CUR_STOP = 4'h7;
    localparam logic [3:0] CUR_DRAW = 4'h8;

    localparam logic [7:0] START8 = 8'(START_X);
    localparam logic [7:0] HIT8   = 8'(HIT_X);
    localparam logic [8:0] HIT9   = 9'(HIT_X);
    localparam logic [8:0] STEP9  = 9'(STEP);
    localparam logic [2:0] WLAST  = 3'(WALL_W - 1);
    localparam logic [6:0] RLAST  = 7'd119;

`ifdef WALL_ERASE_EN
    typedef enum logic [1:0] {IDLE, ERASE, PAINT} rstate_t;
`else
    typedef enum logic [0:0] {IDLE, PAINT} rstate_t;
`endif

    logic       st_move;
    logic       st_draw;
    logic       st_ready;
    logic       tick_pending;
    logic [8:0] diff;
    logic [7:0] moved;

    rstate_t    state;
    rstate_t    nstate;
    logic [6:0] row;
    logic [6:0] nrow;
    logic [2:0] col;
    logic [2:0] ncol;
    logic [7:0] nbase;
    logic [7:0] new_x;
    logic [7:0] drawn_x;
    logic       drawn_valid;
    logic       start;
    logic       done;
    logic       last;
    logic [6:0] adv_row;
    logic [2:0] adv_col;
    logic [8:0] px_sum;
    logic       pix_in;

    // Decode the FSM state code; unknown codes behave as READY.
    always_comb begin
        st_move = 1'b0;
        st_draw = 1'b0;
        case (current)
            CUR_MOVE: st_move = 1'b1;
            CUR_DRAW: st_draw = 1'b1;
            default:  ;
        endcase
        st_ready = !(st_move || st_draw || current == CUR_STOP);
    end

    // Step left with a 9-bit difference so small positions cannot wrap.
    always_comb begin
        diff  = {1'b0, wall_x} - STEP9;
        moved = (diff[8] || diff < HIT9) ? HIT8 : diff[7:0];
    end

    // Position, tick latch and touch status.
    always_ff @(posedge clk) begin
        if (reset) begin
            wall_x       <= START8;
            touched      <= 1'b0;
            tick_pending <= 1'b0;
        end else begin
            touched <= (wall_x <= HIT8);
            if (st_ready) begin
                wall_x       <= START8;
                tick_pending <= 1'b0;
            end else if (st_move) begin
                if (tick_pending && wall_x > HIT8)
                    wall_x <= moved;
                tick_pending <= tick;
            end else if (tick) begin
                tick_pending <= 1'b1;
            end
        end
    end

    // Render engine next state and the coordinates of the next pixel.
    always_comb begin
        last    = (row == RLAST) && (col == WLAST);
        adv_col = (col == WLAST) ? 3'd0 : col + 3'd1;
        adv_row = (col == WLAST) ? row + 7'd1 : row;
        nstate  = state;
        nrow    = adv_row;
        ncol    = adv_col;
        nbase   = new_x;
        start   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                nrow  = 7'd0;
                ncol  = 3'd0;
                nbase = wall_x;
                if (st_draw && (!drawn_valid || drawn_x != wall_x)) begin
                    start  = 1'b1;
`ifdef WALL_ERASE_EN
                    if (drawn_valid) begin
                        nstate = ERASE;
                        nbase  = drawn_x;
                    end else begin
                        nstate = PAINT;
                    end
`else
                    nstate = PAINT;
`endif
                end
            end
`ifdef WALL_ERASE_EN
            ERASE: begin
                nbase = drawn_x;
                if (last) begin
                    nstate = PAINT;
                    nrow   = 7'd0;
                    ncol   = 3'd0;
                    nbase  = new_x;
                end
            end
`endif
            PAINT: begin
                if (last) begin
                    nstate = IDLE;
                    done   = 1'b1;
                end
            end
            default: nstate = IDLE;
        endcase
        px_sum = {1'b0, nbase} + {6'b0, ncol};
        pix_in = (px_sum <= 9'd159);
    end

    // Render engine state, scan counters and bar bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            row         <= 7'd0;
            col         <= 3'd0;
            new_x       <= 8'd0;
            drawn_x     <= 8'd0;
            drawn_valid <= 1'b0;
        end else begin
            state <= nstate;
            row   <= nrow;
            col   <= ncol;
            if (start)
                new_x <= wall_x;
            if (done) begin
                drawn_x     <= new_x;
                drawn_valid <= 1'b1;
            end
        end
    end

    // Pixel outputs registered together; clipped columns scan without plotting.
    always_ff @(posedge clk) begin
        if (reset || nstate == IDLE) begin
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
        end else begin
            vga_x      <= px_sum[7:0];
            vga_y      <= nrow;
            vga_colour <= (nstate == PAINT) ? WALL_COLOUR : 3'd0;
            vga_plot   <= pix_in;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_wall_datapath.sv
// tb_wall_datapath: random and directed stimulus against a behavioural model
// of wall movement and bar rendering, for a default and a wide/fast instance.
module tb_wall_datapath;

`ifdef WALL_ERASE_EN
    localparam bit ER = 1'b1;
`else
    localparam bit ER = 1'b0;
`endif

    localparam int PSTEP [2] = '{1, 7};
    localparam int PW    [2] = '{4, 8};
    localparam int PCOL  [2] = '{2, 6};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] current = 4'h5;

    logic       tw [2];
    logic [7:0] wx [2];
    logic [7:0] vx [2];
    logic [6:0] vy [2];
    logic [2:0] vc [2];
    logic       vp [2];
    logic       vb [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wall_datapath u0 (
        .clk(clk), .reset(reset), .current(current), .tick(tick),
        .touched(tw[0]), .wall_x(wx[0]), .vga_x(vx[0]), .vga_y(vy[0]),
        .vga_colour(vc[0]), .vga_plot(vp[0]), .busy(vb[0])
    );

    wall_datapath #(.STEP(7), .WALL_W(8), .WALL_COLOUR(3'b110)) u1 (
        .clk(clk), .reset(reset), .current(current), .tick(tick),
        .touched(tw[1]), .wall_x(wx[1]), .vga_x(vx[1]), .vga_y(vy[1]),
        .vga_colour(vc[1]), .vga_plot(vp[1]), .busy(vb[1])
    );

    task automatic chk(string nm, int k, logic [31:0] act, int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t",
                     nm, k, act, exp, $time);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: position, pending tick, and a render job described
    // as a pixel index over an (optional erase +) paint pixel list.
    int mx [2], mdx [2], mnx [2], meb [2], midx [2], mtot [2];
    bit mt [2], mp [2], ms [2], mdv [2], mer [2];

    function automatic void exp_pix(int k, output int px, output int py,
                                    output int pc, output int pp);
        int n, j, base;
        n = 120 * PW[k];
        if (mer[k] && midx[k] < n) begin
            j = midx[k]; base = meb[k]; pc = 0;
        end else begin
            j = midx[k] - (mer[k] ? n : 0); base = mnx[k]; pc = PCOL[k];
        end
        py = j / PW[k];
        px = base + j % PW[k];
        pp = (px <= 159) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        bit mov, drw, rdy;
        int xp, px, py, pc, pp;
        mov = (current == 4'h6);
        drw = (current == 4'h8);
        rdy = !(mov || drw || current == 4'h7);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mx[k] = 156; mt[k] = 0; mp[k] = 0; ms[k] = 0; mdv[k] = 0;
            end else begin
                xp = mx[k];
                mt[k] = (xp <= 20);
                if (rdy) begin
                    mx[k] = 156; mp[k] = 0;
                end else if (mov) begin
                    if (mp[k] && xp > 20)
                        mx[k] = (xp - PSTEP[k] < 20) ? 20 : xp - PSTEP[k];
                    mp[k] = tick;
                end else if (tick) begin
                    mp[k] = 1;
                end
                if (ms[k]) begin
                    midx[k]++;
                    if (midx[k] == mtot[k]) begin
                        ms[k] = 0; mdx[k] = mnx[k]; mdv[k] = 1;
                    end
                end else if (drw && (!mdv[k] || mdx[k] != xp)) begin
                    mnx[k] = xp; meb[k] = mdx[k];
                    mer[k] = ER && mdv[k];
                    mtot[k] = (mer[k] ? 2 : 1) * 120 * PW[k];
                    midx[k] = 0; ms[k] = 1;
                end
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("wall_x", k, wx[k], mx[k]);
            chk("touched", k, tw[k], mt[k]);
            chk("busy", k, vb[k], ms[k]);
            if (ms[k]) begin
                exp_pix(k, px, py, pc, pp);
                chk("vga_plot", k, vp[k], pp);
                chk("vga_x", k, vx[k], px & 255);
                chk("vga_y", k, vy[k], py);
                chk("vga_colour", k, vc[k], pc);
            end else begin
                chk("idle_plot", k, vp[k], 0);
            end
        end
    end

    initial begin
        int c0, c1, r;
        reset = 1'b1; current = 4'h5; tick = 1'b0;
        cyc(2);
        chk("lit_rst_x", 0, wx[0], 156);
        chk("lit_rst_busy", 0, vb[0], 0);
        chk("lit_rst_plot", 0, vp[0], 0);
        reset = 1'b0;
        cyc(5);
        chk("lit_ready_x", 1, wx[1], 156);
        chk("lit_ready_touch", 0, tw[0], 0);

        current = 4'h8; cyc(1); current = 4'h7;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 1000; i++) begin
            c0 += int'(vp[0]); c1 += int'(vp[1]); cyc(1);
        end
        chk("lit_paint_plots", 0, c0, 480);
        chk("lit_clip_plots", 1, c1, 480);
        chk("lit_paint_done", 0, vb[0], 0);

        current = 4'h8; tick = 1'b1; cyc(1);
        tick = 1'b0; current = 4'h6; cyc(1);
        chk("lit_move_x", 0, wx[0], 155);
        chk("lit_move_x", 1, wx[1], 149);
        current = 4'h8; cyc(1); current = 4'h7;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 2000; i++) begin
            if (vp[0] && vc[0] == 3'd0) c0++;
            if (vp[0] && vc[0] == 3'd2) c1++;
            cyc(1);
        end
        chk("lit_erase_plots", 0, c0, ER ? 480 : 0);
        chk("lit_repaint_plots", 0, c1, 480);

        current = 4'h6; tick = 1'b1; cyc(200);
        chk("lit_sat_x", 0, wx[0], 20);
        chk("lit_sat_x", 1, wx[1], 20);
        chk("lit_sat_touch", 1, tw[1], 1);
        current = 4'h7; tick = 1'b1; cyc(1);
        tick = 1'b0; current = 4'h5; cyc(1);
        chk("lit_reload_x", 0, wx[0], 156);
        chk("lit_touch_lag", 0, tw[0], 1);
        cyc(1);
        chk("lit_touch_clr", 0, tw[0], 0);
        current = 4'h6; cyc(2);
        chk("lit_pend_clr", 0, wx[0], 156);

        reset = 1'b1; cyc(1); reset = 1'b0;
        current = 4'h8; cyc(1); current = 4'h7;
        cyc(100);
        reset = 1'b1; cyc(1); reset = 1'b0;
        chk("lit_rst_mid_plot", 0, vp[0], 0);
        chk("lit_rst_mid_busy", 0, vb[0], 0);
        current = 4'h8; cyc(1); current = 4'h7;
        chk("lit_no_erase_col", 0, vc[0], 2);
        cyc(1000);
        current = 4'h6; tick = 1'b1; cyc(1);
        tick = 1'b0; cyc(1);
        current = 4'h8; cyc(1); current = 4'h7;
        c0 = 0;
        for (int i = 0; i < 2000; i++) begin
            if (vp[0] && vc[0] == 3'd0) c0++;
            cyc(1);
        end
        chk("lit_erase_again", 0, c0, ER ? 480 : 0);

        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 15));
            if (r < 5)       current = 4'h6;
            else if (r < 9)  current = 4'h8;
            else if (r < 12) current = 4'h7;
            else if (r < 14) current = 4'h5;
            else             current = 4'($urandom_range(9, 15));
            tick  = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 599) == 0);
            cyc(1);
        end
        reset = 1'b0;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
